// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB bus arbiter: transfer/burst encodings, FSM state
// constants and the burst-length decode used by the beat counter.
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_t;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_PARK  = 2'd0;
   localparam arb_state_t ST_OWN   = 2'd1;
   localparam arb_state_t ST_BURST = 2'd2;
   localparam arb_state_t ST_LOCK  = 2'd3;

   // Undefined-length INCR is treated as a burst of max_incr beats so it can be preempted.
   function automatic int unsigned burst_beats(hburst_t b, int unsigned max_incr);
      int unsigned beats;
      case (b)
         HBURST_SINGLE:                beats = 1;
         HBURST_INCR:                  beats = max_incr;
         HBURST_WRAP4,  HBURST_INCR4:  beats = 4;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 8;
         default:                      beats = 16;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: scans req starting one past ptr and
// returns the first requester as a one-hot vector.
module ahb_rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         winner,
   output logic                 valid
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // k runs to N so the previous owner is considered last.
      for (int k = 1; k <= N; k++) begin
         idx = IDX_W'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB address/control bus arbiter: round-robin grants, burst-boundary
// rearbitration, INCR fairness cap, locked transfers and default-master parking.
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_INCR_BEATS = 16
) (
   input  logic                           hclk,
   input  logic                           hreset,
   input  logic [NUM_MASTERS-1:0]         hbusreq,
   input  logic [NUM_MASTERS-1:0]         hlock,
   input  logic [1:0]                     htrans,
   input  logic [2:0]                     hburst,
   input  logic                           hready,
   output logic [NUM_MASTERS-1:0]         hgrant,
   output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
   output logic                           hmastlock
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int CNT_W = $clog2((MAX_INCR_BEATS > 16 ? MAX_INCR_BEATS : 16) + 1);
   localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [IDX_W-1:0] DEFAULT_IDX = IDX_W'(DEFAULT_MASTER);

   htrans_t                trans;
   hburst_t                burst;
   arb_state_t             state_reg, state_next;
   logic [NUM_MASTERS-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0]       master_reg, master_next;
   logic                   mastlock_reg, mastlock_next;
   logic [IDX_W-1:0]       ptr_reg, ptr_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   tail_reg, tail_next;

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       owner_idx;
   logic [CNT_W-1:0]       new_beats;
   logic                   owner_req, owner_lock, settled;
   logic                   beat_accept, idle_accept, last_beat, rearb;

   assign trans = htrans_t'(htrans);
   assign burst = hburst_t'(hburst);

   ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req    (hbusreq),
      .ptr    (ptr_reg),
      .winner (pick_onehot),
      .valid  (pick_valid)
   );

   always_comb begin
      owner_idx = '0;
      pick_idx  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_reg[i])   owner_idx = IDX_W'(i);
         if (pick_onehot[i]) pick_idx  = IDX_W'(i);
      end
   end

   assign owner_req   = hbusreq[owner_idx];
   assign owner_lock  = hlock[owner_idx];
   // htrans/hburst belong to hmaster, so they only describe the grant owner once hmaster caught up.
   assign settled     = (master_reg == owner_idx);
   assign new_beats   = CNT_W'(burst_beats(burst, MAX_INCR_BEATS));
   assign beat_accept = hready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
   assign idle_accept = hready && (trans == HTRANS_IDLE);

   always_comb begin
      cnt_next = cnt_reg;
      if (hready && trans == HTRANS_NONSEQ)
         cnt_next = new_beats;
      else if (hready && trans == HTRANS_SEQ && cnt_reg != '0)
         cnt_next = cnt_reg - CNT_W'(1);
   end

   assign last_beat = beat_accept && (cnt_next == CNT_W'(1));

   always_comb begin
      state_next = state_reg;
      tail_next  = tail_reg;
      rearb      = 1'b0;
      case (state_reg)
         ST_PARK: rearb = hready;
         ST_OWN: begin
            if (owner_lock) begin
               state_next = ST_LOCK;
               tail_next  = 1'b0;
            end else if (settled && hready && trans == HTRANS_NONSEQ && new_beats > CNT_W'(1))
               state_next = ST_BURST;
            else
               rearb = hready && (!owner_req || (settled && (idle_accept || last_beat)));
         end
         ST_BURST: begin
            if (owner_lock) begin
               state_next = ST_LOCK;
               tail_next  = 1'b0;
            end else
               rearb = settled && (last_beat || idle_accept);
         end
         ST_LOCK: begin
            // After hlock drops, one more accepted cycle carries the locked tail.
            if (owner_lock)
               tail_next = 1'b0;
            else if (hready) begin
               if (tail_reg) begin
                  rearb     = 1'b1;
                  tail_next = 1'b0;
               end else
                  tail_next = 1'b1;
            end
         end
         default: state_next = ST_PARK;
      endcase
      if (rearb)
         state_next = pick_valid ? ST_OWN : ST_PARK;
   end

   always_comb begin
      grant_next    = grant_reg;
      ptr_next      = ptr_reg;
      master_next   = master_reg;
      mastlock_next = mastlock_reg;
      if (rearb) begin
         if (pick_valid) begin
            grant_next = pick_onehot;
            ptr_next   = pick_idx;
         end else
            grant_next = DEFAULT_GRANT;
      end
      if (hready) begin
         master_next   = owner_idx;
         mastlock_next = owner_lock;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_reg    <= ST_PARK;
         grant_reg    <= DEFAULT_GRANT;
         master_reg   <= DEFAULT_IDX;
         mastlock_reg <= 1'b0;
         ptr_reg      <= DEFAULT_IDX;
         cnt_reg      <= '0;
         tail_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         master_reg   <= master_next;
         mastlock_reg <= mastlock_next;
         ptr_reg      <= ptr_next;
         cnt_reg      <= cnt_next;
         tail_reg     <= tail_next;
      end
   end

   assign hgrant    = grant_reg;
   assign hmaster   = master_reg;
   assign hmastlock = mastlock_reg;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scenario bench for ahb_bus_arbiter: per-cycle expectations are queued with the
// stimulus and compared against the sampled grant/master/lock outputs.
module tb_ahb_bus_arbiter;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0;
   localparam logic [2:0] INCR   = 3'd1;
   localparam logic [2:0] INCR4  = 3'd3;
   localparam logic [2:0] WRAP8  = 3'd4;
   localparam logic [2:0] INCR8  = 3'd5;
   localparam logic [2:0] INCR16 = 3'd7;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] master;
      logic       lock;
   } obs_t;

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hbusreq, hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hmastlock;

   obs_t  exp_q[$];
   obs_t  obs_q[$];
   int    checks   = 0;
   int    failures = 0;
   string test_name;

   ahb_bus_arbiter #(
      .NUM_MASTERS    (4),
      .DEFAULT_MASTER (0),
      .MAX_INCR_BEATS (16)
   ) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hburst    (hburst),
      .hready    (hready),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmastlock (hmastlock)
   );

   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      hreset  = 1'b1;
      hbusreq = '0;
      hlock   = '0;
      htrans  = IDLE;
      hburst  = SINGLE;
      hready  = 1'b1;
      repeat (2) @(posedge hclk);
      #1 hreset = 1'b0;
   endtask

   // Drive one cycle, queue what the outputs must be after the edge, sample them.
   task automatic cyc(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] trans,
                      input logic [2:0] burst, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic el);
      obs_t e, o;
      hbusreq = req;
      hlock   = lck;
      htrans  = trans;
      hburst  = burst;
      hready  = rdy;
      e.grant = eg; e.master = em; e.lock = el;
      exp_q.push_back(e);
      @(posedge hclk);
      #1;
      o.grant = hgrant; o.master = hmaster; o.lock = hmastlock;
      obs_q.push_back(o);
   endtask

   task automatic test_reset();
      obs_t e, o;
      test_name = "reset";
      do_reset();
      checks++;
      if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: hgrant=%b hmaster=%0d hmastlock=%b, required 0001/0/0", hgrant, hmaster, hmastlock);
      end
      repeat (3) cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      cyc(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0);
      cyc(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0100, 4'b0000, NONSEQ, INCR8,  1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0100, 4'b0000, SEQ,    INCR8,  1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0100, 4'b0000, SEQ,    INCR8,  1'b1, 4'b0100, 2'd2, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
      #2 hreset = 1'b1;
      #1;
      checks++;
      if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_mid_incr8: hgrant=%b hmaster=%0d hmastlock=%b, required 0001/0/0", hgrant, hmaster, hmastlock);
      end else
         $display("ok   async_reset_mid_incr8: hgrant=%b hmaster=%0d", hgrant, hmaster);
      @(posedge hclk);
      #1 hreset = 1'b0;
      cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s_after cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s_after cycle %0d: hgrant=%b hmaster=%0d", test_name, n, o.grant, o.master);
      end
   endtask

   task automatic test_round_robin_single();
      obs_t e, o;
      test_name = "rr_single";
      do_reset();
      cyc(4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
      cyc(4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
      cyc(4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
      cyc(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0);
      cyc(4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
   endtask

   task automatic test_burst_boundary();
      obs_t e, o;
      test_name = "incr4_boundary";
      do_reset();
      cyc(4'b1000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd0, 1'b0);
      cyc(4'b1000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0);
      cyc(4'b1001, 4'b0000, NONSEQ, INCR4,  1'b1, 4'b1000, 2'd3, 1'b0);
      cyc(4'b1001, 4'b0000, SEQ,    INCR4,  1'b1, 4'b1000, 2'd3, 1'b0);
      cyc(4'b1001, 4'b0000, SEQ,    INCR4,  1'b1, 4'b1000, 2'd3, 1'b0);
      cyc(4'b1001, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0001, 2'd3, 1'b0);
      cyc(4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
   endtask

   task automatic test_incr_cap();
      obs_t e, o;
      test_name = "incr_cap";
      do_reset();
      cyc(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0);
      cyc(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0110, 4'b0000, NONSEQ, INCR,   1'b1, 4'b0100, 2'd2, 1'b0);
      for (int k = 2; k <= 15; k++)
         cyc(4'b0110, 4'b0000, SEQ, INCR, 1'b1, 4'b0100, 2'd2, 1'b0);
      cyc(4'b0110, 4'b0000, SEQ,    INCR,   1'b1, 4'b0010, 2'd2, 1'b0);
      cyc(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
   endtask

   task automatic test_locked();
      obs_t e, o;
      test_name = "locked";
      do_reset();
      cyc(4'b0010, 4'b0010, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
      cyc(4'b0010, 4'b0010, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1);
      cyc(4'b0111, 4'b0010, NONSEQ, INCR16, 1'b1, 4'b0010, 2'd1, 1'b1);
      for (int k = 2; k <= 16; k++)
         cyc(4'b0111, 4'b0010, SEQ, INCR16, 1'b1, 4'b0010, 2'd1, 1'b1);
      cyc(4'b0111, 4'b0010, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1);
      cyc(4'b0111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);
      cyc(4'b0111, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
      cyc(4'b0101, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
   endtask

   task automatic test_hready_hold();
      obs_t e, o;
      test_name = "hready_hold";
      do_reset();
      cyc(4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      cyc(4'b1001, 4'b0000, NONSEQ, WRAP8,  1'b1, 4'b0001, 2'd0, 1'b0);
      for (int k = 2; k <= 7; k++)
         cyc(4'b1001, 4'b0000, SEQ, WRAP8, 1'b1, 4'b0001, 2'd0, 1'b0);
      repeat (3) cyc(4'b1001, 4'b0000, SEQ, WRAP8, 1'b0, 4'b0001, 2'd0, 1'b0);
      cyc(4'b1001, 4'b0000, SEQ,    WRAP8,  1'b1, 4'b1000, 2'd0, 1'b0);
      cyc(4'b1000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0);
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o.grant !== e.grant || o.master !== e.master || o.lock !== e.lock) begin
            failures++;
            $display("FAIL %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b, required %b/%0d/%b", test_name, n, o.grant, o.master, o.lock, e.grant, e.master, e.lock);
         end else
            $display("ok   %s cycle %0d: hgrant=%b hmaster=%0d hmastlock=%b", test_name, n, o.grant, o.master, o.lock);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin_single();
      test_burst_boundary();
      test_incr_cap();
      test_locked();
      test_hready_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares the AHB address/control bus between up to NUM_MASTERS requesting masters and parks the bus on a default master when idle.
- Sits between the master ports and the bus address/control mux, and drives that mux via hmaster.
- Grants are round-robin with burst-boundary rearbitration, an INCR fairness cap and locked-transfer support.
- It is the sequencing block the AHB slave under verification sees in multi-master configurations.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- DEFAULT_MASTER, 0, index granted when no master requests (bus parking).
- MAX_INCR_BEATS, 16, beats after which an undefined-length INCR burst may be preempted.

Ports:
- hclk, in, 1, bus clock; all state updates on rising edge.
- hreset, in, 1, asynchronous active-high reset.
- hbusreq, in, NUM_MASTERS, per-master bus request.
- hlock, in, NUM_MASTERS, per-master locked-access request.
- htrans, in, 2, transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst, in, 3, burst type of the current address-phase owner.
- hready, in, 1, bus-wide transfer-complete / phase-advance.
- hgrant, out, NUM_MASTERS, one-hot grant (registered).
- hmaster, out, clog2(NUM_MASTERS), index of the master owning the address phase.
- hmastlock, out, 1, current address-phase transfer is locked.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - hgrant = one-hot DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0.
  - Round-robin pointer = DEFAULT_MASTER; beat counter = 0; FSM = PARK.
- Handover:
  - hgrant changes only on a rising edge where hready=1.
  - hmaster and hmastlock load (next owner index, hlock[next owner]) on the first hready=1 edge after hgrant moves.
  - Minimum handover latency: request to hgrant is 1 cycle; hgrant to hmaster is 1 cycle.
- Round-robin picker:
  - Search starts at (last owner+1) mod NUM_MASTERS.
  - First master with hbusreq=1 wins; the pointer updates to the winner on grant.
  - No requesters: grant DEFAULT_MASTER.
- Beat counter, loaded on an accepted NONSEQ (htrans=NONSEQ, hready=1):
  - SINGLE -> 1; INCR4/WRAP4 -> 4; INCR8/WRAP8 -> 8; INCR16/WRAP16 -> 16; INCR -> MAX_INCR_BEATS.
  - Decrements on an accepted SEQ and saturates at 0.
  - BUSY and IDLE never change it.
- FSM states:
  - PARK: default master granted, no request. Go to OWN when any hbusreq is set and hready=1.
  - OWN: granted master's bus is IDLE. Go to BURST on an accepted NONSEQ of a multi-beat burst. Go to LOCK if hlock[owner]=1.
  - BURST: rearbitration blocked until the beat being accepted has counter==1; grant may then move in that same cycle. Return to OWN/PARK at the burst end.
  - LOCK: no rearbitration while hlock[owner]=1. One extra cycle after hlock drops (locked-transfer tail), then rearbitrate.
- Rearbitration points:
  - Owner htrans=IDLE with hready=1.
  - Last burst beat.
  - INCR counter reaching 1.
  - Owner deasserts hbusreq while not in BURST.
  - Never during LOCK.
- Simultaneous events:
  - Owner drops hbusreq on the last beat while others request: grant moves to the next requester in round-robin order.
  - Owner still requesting at a rearbitration point with others requesting: round-robin passes it over.
  - hready=0 at a rearbitration point: decision is held until hready=1, re-evaluated with the current requests.
- Invariants:
  - hgrant is always exactly one-hot.
  - hmaster always equals the index of the grant held on the previous accepted edge.

Decomposition:
- ahb_arb_pkg holds:
  - htrans_t and hburst_t enums;
  - arb_state_t (PARK, OWN, BURST, LOCK);
  - function burst_beats(hburst_t, max_incr) returning the beat count.
- Sub-module ahb_rr_picker: combinational; inputs req vector and pointer, outputs one-hot winner and a valid flag.

Test Plan:
- Reset then no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0. Assert hreset mid-INCR8 -> same values asynchronously.
- M1 and M2 request together; M1 runs SINGLE then IDLE -> hgrant 4'b0010, then 4'b0100 on the next hready edge; hmaster 1 then 2.
- M3 runs INCR4 while M0 requests -> grant stays 4'b1000 for beats 1-3, moves to 4'b0001 during beat 4; hmaster=0 on the following edge.
- M2 runs INCR (undefined length) with M1 requesting, MAX_INCR_BEATS=16 -> grant moves to M1 at beat 16 exactly.
- M1 has hlock=1 with an INCR16 plus a further SINGLE, M0/M2 requesting -> no handover until hlock drops plus 1 cycle; hmastlock=1 throughout.
- M0 WRAP8 with hready low for 3 cycles on the last beat, M3 requesting -> grant change delayed until hready=1, then 4'b1000.
